rsc_encoder: RTL and testbench

RSC_ENCODER -- requirements
Module: rsc_encoder

---
 rtl/siso_pkg.sv | 27 ++
 rtl/rsc_trellis_step.sv | 26 ++
 rtl/rsc_encoder.sv | 162 ++++++++++++++++
 tb/tb_rsc_encoder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/siso_pkg.sv
// Shared definitions for the RSC encoder: FSM state encoding, output
// amplitude, block-length limit, trellis tail length and the bit-to-word
// mapping helper.
package siso_pkg;

  // Encoder sequencing states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SYS      = 3'd1,
    ST_PAR      = 3'd2,
    ST_TAIL_SYS = 3'd3,
    ST_TAIL_PAR = 3'd4
  } enc_state_e;

  localparam int ENC_AMP      = 64;
  localparam int ENC_MAX_BLK  = 512;
  localparam int ENC_TAIL_LEN = 3;
  localparam int WORD_W       = 16;

  // Bit 0 maps to +amp, bit 1 maps to -amp (two's complement).
  function automatic logic [WORD_W-1:0] map_bit(input logic b, input int amp);
    logic [WORD_W-1:0] mag;
    mag = WORD_W'(amp);
    return b ? (~mag + 16'd1) : mag;
  endfunction

endpackage

// File: rtl/rsc_trellis_step.sv
// One trellis step of the LTE constituent RSC code (feedback 13o,
// forward 15o). Purely combinational.
// State bit mapping: s_i[0] = s1, s_i[1] = s2, s_i[2] = s3.
module rsc_trellis_step (
  input  logic [2:0] s_i,
  input  logic       c_i,
  input  logic       tail_i,
  output logic       x_o,
  output logic       z_o,
  output logic [2:0] s_next_o
);

  logic c_eff;
  logic a;

  // During termination the input is forced to the feedback value, which
  // drives the register input to zero and flushes the state back to 000.
  always_comb begin
    c_eff    = tail_i ? (s_i[1] ^ s_i[2]) : c_i;
    a        = c_eff ^ s_i[1] ^ s_i[2];
    x_o      = c_eff;
    z_o      = a ^ s_i[0] ^ s_i[2];
    s_next_o = {s_i[1], s_i[0], a};
  end

endmodule

// File: rtl/rsc_encoder.sv
// RSC encoder with valid/ready streaming on both sides. Each information
// bit yields a systematic word then a parity word; after K bits three tail
// steps terminate the trellis. Words are mapped to +/-AMP.
//
// state    | meaning
// ---------|---------------------------------------------------------
// IDLE     | no block in progress (last word may still await handshake)
// SYS      | waiting for an information bit; emits systematic word
// PAR      | emitting the parity word of the bit just accepted
// TAIL_SYS | emitting a tail systematic word (no input consumed)
// TAIL_PAR | emitting a tail parity word; last one ends the block
module rsc_encoder
  import siso_pkg::*;
#(
  parameter int MAX_BLK = ENC_MAX_BLK,
  parameter int AMP     = ENC_AMP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] blklen,
  input  logic        bit_in,
  input  logic        valid_in,
  output logic        ready_in,
  output logic [15:0] out,
  output logic        valid_out,
  input  logic        ready_out,
  output logic        last_out,
  output logic        busy,
  output logic        err
);

  localparam logic [15:0] MAX_K    = 16'(MAX_BLK);
  localparam logic [1:0]  TAIL_END = 2'(ENC_TAIL_LEN - 1);

  enc_state_e  state_q;
  logic [2:0]  s_q;
  logic [15:0] k_q;
  logic [15:0] cnt_q;
  logic [1:0]  tail_q;
  logic        zpend_q;
  logic [15:0] out_q;
  logic        valid_q;
  logic        last_q;
  logic        err_q;

  logic        x_w;
  logic        z_w;
  logic [2:0]  s_next_w;
  logic        slot_free;
  logic        len_ok;

  rsc_trellis_step u_step (
    .s_i      (s_q),
    .c_i      (bit_in),
    .tail_i   (state_q == ST_TAIL_SYS),
    .x_o      (x_w),
    .z_o      (z_w),
    .s_next_o (s_next_w)
  );

  // The output register can take a new word when empty or being drained.
  assign slot_free = !valid_q || ready_out;
  assign len_ok    = (blklen != 16'd0) && (blklen <= MAX_K);

  assign ready_in  = (state_q == ST_SYS) && slot_free;
  assign busy      = (state_q != ST_IDLE) || valid_q;
  assign out       = out_q;
  assign valid_out = valid_q;
  assign last_out  = last_q;
  assign err       = err_q;

  // Block sequencing, trellis state update and output word register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= 3'b000;
      k_q     <= 16'd0;
      cnt_q   <= 16'd0;
      tail_q  <= 2'd0;
      zpend_q <= 1'b0;
      out_q   <= 16'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (ready_out) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          // A start arriving while the final word is still pending is ignored.
          if (start && !busy) begin
            if (len_ok) begin
              state_q <= ST_SYS;
              k_q     <= blklen;
              cnt_q   <= 16'd0;
              tail_q  <= 2'd0;
              s_q     <= 3'b000;
            end else begin
              err_q <= 1'b1;
            end
          end
        end

        ST_SYS: begin
          if (valid_in && slot_free) begin
            out_q   <= map_bit(x_w, AMP);
            valid_q <= 1'b1;
            last_q  <= 1'b0;
            zpend_q <= z_w;
            s_q     <= s_next_w;
            cnt_q   <= cnt_q + 16'd1;
            state_q <= ST_PAR;
          end
        end

        ST_PAR: begin
          if (slot_free) begin
            out_q   <= map_bit(zpend_q, AMP);
            valid_q <= 1'b1;
            last_q  <= 1'b0;
            state_q <= (cnt_q == k_q) ? ST_TAIL_SYS : ST_SYS;
          end
        end

        ST_TAIL_SYS: begin
          if (slot_free) begin
            out_q   <= map_bit(x_w, AMP);
            valid_q <= 1'b1;
            last_q  <= 1'b0;
            zpend_q <= z_w;
            s_q     <= s_next_w;
            state_q <= ST_TAIL_PAR;
          end
        end

        ST_TAIL_PAR: begin
          if (slot_free) begin
            out_q   <= map_bit(zpend_q, AMP);
            valid_q <= 1'b1;
            if (tail_q == TAIL_END) begin
              last_q  <= 1'b1;
              tail_q  <= 2'd0;
              state_q <= ST_IDLE;
            end else begin
              last_q  <= 1'b0;
              tail_q  <= tail_q + 2'd1;
              state_q <= ST_TAIL_SYS;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsc_encoder.sv
// Scoreboard bench for rsc_encoder: expected words are queued when a block
// is issued, a negedge monitor pops and compares on every output handshake.
module tb_rsc_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] blklen = 16'd0;
  logic        bit_in = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_in;
  logic [15:0] out;
  logic        valid_out;
  logic        ready_out = 1'b1;
  logic        last_out;
  logic        busy;
  logic        err;

  rsc_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .blklen    (blklen),
    .bit_in    (bit_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .out       (out),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .last_out  (last_out),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   words_seen = 0;
  int   ready_mode = 0;
  bit   mon_en = 1'b0;
  logic blk_bits [0:1023];

  bit          prev_stall = 1'b0;
  logic [15:0] prev_out;
  logic        prev_last;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream back-pressure: 0 = always ready, 1 = toggle, 2 = random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: ready_out = 1'b1;
      1: ready_out = !ready_out;
      default: ready_out = ($urandom_range(0, 2) != 0);
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare each handshaked word, verify stall stability and ready_in.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, valid_out}, 32'd1);
        check("stall_out", {16'd0, out}, {16'd0, prev_out});
        check("stall_last", {31'd0, last_out}, {31'd0, prev_last});
      end
      if (valid_out && !ready_out)
        check("ready_in_while_stalled", {31'd0, ready_in}, 32'd0);
      if (valid_out && ready_out) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_word: got %0h expected none at cycle %0d", out, cyc);
        end else begin
          e = exp_q.pop_front();
          check("word", {16'd0, out}, {16'd0, e.w});
          check("last", {31'd0, last_out}, {31'd0, e.l});
          words_seen++;
        end
      end
      prev_stall = valid_out && !ready_out;
      prev_out   = out;
      prev_last  = last_out;
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic logic [15:0] word_of(input logic b);
    return b ? 16'hFFC0 : 16'h0040;
  endfunction

  task automatic push_word(input logic b, input logic l);
    exp_t e;
    e.w = word_of(b);
    e.l = l;
    exp_q.push_back(e);
  endtask

  // Reference model on the feedback sequence a[n]: s1,s2,s3 = a[n-1..n-3].
  task automatic push_model(input int k);
    logic ah [0:1100];
    logic c, a, z, x;
    int   nw, idx, n;
    nw  = 2 * k + 6;
    idx = 0;
    ah[0] = 0; ah[1] = 0; ah[2] = 0;
    for (int i = 0; i < k; i++) begin
      c = blk_bits[i];
      a = c ^ ah[i + 1] ^ ah[i];
      z = a ^ ah[i + 2] ^ ah[i];
      ah[i + 3] = a;
      push_word(c, idx == nw - 1); idx++;
      push_word(z, idx == nw - 1); idx++;
    end
    for (int t = 0; t < 3; t++) begin
      n = k + t;
      x = ah[n + 1] ^ ah[n];
      z = ah[n + 2] ^ ah[n];
      ah[n + 3] = 0;
      push_word(x, idx == nw - 1); idx++;
      push_word(z, idx == nw - 1); idx++;
    end
  endtask

  task automatic start_block(input int k, output int c0);
    @(posedge clk); #1;
    start  = 1'b1;
    blklen = 16'(k);
    @(posedge clk); #1;
    start  = 1'b0;
    blklen = 16'($urandom_range(0, 65535));
    c0 = cyc;
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic feed_bits(input int n, input bit gaps);
    bit acc;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        valid_in = 1'b0;
        @(posedge clk); #1;
      end
      valid_in = 1'b1;
      bit_in   = blk_bits[i];
      acc = 1'b0;
      for (int w = 0; w < 200 && !acc; w++) begin
        @(negedge clk);
        if (ready_in) acc = 1'b1;
        @(posedge clk); #1;
      end
      if (!acc) begin
        check("bit_accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic finish_block(input int k, input int c0, input int w0, input bit tput);
    bit done;
    done = 1'b0;
    for (int w = 0; w < 20000 && !done; w++) begin
      if (exp_q.size() == 0 && !busy) done = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("block_done", {31'd0, done}, 32'd1);
    check("word_count", 32'(words_seen - w0), 32'(2 * k + 6));
    if (tput) check("throughput_cycles", 32'(cyc - c0), 32'(2 * k + 7));
    check("err_idle", {31'd0, err}, 32'd0);
  endtask

  task automatic run_block(input int k, input int mode, input bit gaps, input bit tput, input bit busy_start);
    int c0, w0;
    ready_mode = mode;
    w0 = words_seen;
    start_block(k, c0);
    if (busy_start) begin
      start  = 1'b1;
      blklen = 16'd0;
      @(posedge clk); #1;
      start = 1'b0;
      check("no_err_when_busy", {31'd0, err}, 32'd0);
      check("busy_kept", {31'd0, busy}, 32'd1);
    end
    feed_bits(k, gaps);
    finish_block(k, c0, w0, tput);
  endtask

  task automatic bad_start(input logic [15:0] len);
    @(posedge clk); #1;
    start  = 1'b1;
    blklen = len;
    @(posedge clk); #1;
    start = 1'b0;
    check("err_pulse", {31'd0, err}, 32'd1);
    check("err_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("err_one_cycle", {31'd0, err}, 32'd0);
    check("err_idle_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_out", {16'd0, out}, 32'd0);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_last", {31'd0, last_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_ready_in", {31'd0, ready_in}, 32'd0);
  endtask

  task automatic push_k4_directed();
    logic codes [0:13];
    codes = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 14; i++) push_word(codes[i], i == 13);
  endtask

  task automatic push_k1_directed();
    logic codes [0:7];
    codes = '{1, 1, 0, 1, 1, 0, 1, 1};
    for (int i = 0; i < 8; i++) push_word(codes[i], i == 7);
  endtask

  initial begin
    int k, c0, w0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;
    mon_en = 1'b1;

    // K=4, bits 1011, always ready, full throughput
    blk_bits[0] = 1; blk_bits[1] = 0; blk_bits[2] = 1; blk_bits[3] = 1;
    push_k4_directed();
    run_block(4, 0, 1'b0, 1'b1, 1'b0);

    // K=1, bit 1; trellis must be back at zero
    blk_bits[0] = 1;
    push_k1_directed();
    run_block(1, 0, 1'b0, 1'b1, 1'b0);
    check("state_zero_k1", {29'd0, dut.s_q}, 32'd0);

    // K=4 with ready_out toggling
    blk_bits[0] = 1; blk_bits[1] = 0; blk_bits[2] = 1; blk_bits[3] = 1;
    push_k4_directed();
    run_block(4, 1, 1'b0, 1'b0, 1'b0);

    // Rejected lengths
    ready_mode = 0;
    bad_start(16'd0);
    bad_start(16'd513);

    // Maximum length, all-zero bits: every word +64
    for (int i = 0; i < 512; i++) blk_bits[i] = 0;
    for (int i = 0; i < 1030; i++) push_word(1'b0, i == 1029);
    run_block(512, 0, 1'b0, 1'b1, 1'b0);

    // Abort mid-block with reset, then K=1 must reproduce the directed result
    blk_bits[0] = 1; blk_bits[1] = 0; blk_bits[2] = 1; blk_bits[3] = 1;
    push_k4_directed();
    ready_mode = 0;
    start_block(4, c0);
    feed_bits(3, 1'b0);
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs();
    check("rst_state_zero", {29'd0, dut.s_q}, 32'd0);
    exp_q.delete();
    rst = 1'b0;
    mon_en = 1'b1;
    blk_bits[0] = 1;
    push_k1_directed();
    run_block(1, 0, 1'b0, 1'b1, 1'b0);
    check("state_zero_after_abort", {29'd0, dut.s_q}, 32'd0);

    // Random blocks against the reference model, random back-pressure and gaps
    for (int b = 0; b < 10; b++) begin
      k = $urandom_range(1, 40);
      for (int i = 0; i < k; i++) blk_bits[i] = 1'($urandom_range(0, 1));
      push_model(k);
      run_block(k, 2, 1'b1, 1'b0, (b % 3) == 0);
    end

    // Random block at full rate through the model
    k = 33;
    for (int i = 0; i < k; i++) blk_bits[i] = 1'($urandom_range(0, 1));
    push_model(k);
    w0 = words_seen;
    run_block(k, 0, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
